cpu_control_sequencer: RTL

Multicycle control unit for the simple RAM-backed processor. It fetches a 12-bit instruction word from the data-in bus into an internal instruction register. It then steps through time-steps T1–T3 to drive the register-file, accumulator (A), ALU result register (G), bus-select and PC-increment controls for mv, mvi, add and sub. It sits between the program RAM/PC and the datapath. It replaces the purely combinational opcode-to-next-state decoding with a registered state machine that has a run/done handshake and a retired-instruction counter.

---
 rtl/cpu_control_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cpu_control_sequencer.sv
// Multicycle control sequencer: fetches a 12-bit instruction, then steps T1-T3 to drive
// register-file, accumulator, ALU and bus controls for nop/mv/mvi/add/sub.
module cpu_control_sequencer #(
   parameter int NREG   = 8,
   parameter int DATA_W = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic [DATA_W-1:0] din,
   output logic [11:0]       ir_out,
   output logic [NREG-1:0]   r_in,
   output logic [NREG-1:0]   r_out,
   output logic              din_out,
   output logic              a_in,
   output logic              g_in,
   output logic              g_out,
   output logic              addsub,
   output logic              pc_incr,
   output logic              done,
   output logic              illegal,
   output logic [15:0]       instr_count
);

   typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3} state_t;
   typedef enum logic [3:0] {OP_NOP = 4'h0, OP_MV = 4'h1, OP_MVI = 4'h2,
                             OP_ADD = 4'h3, OP_SUB = 4'h4} opcode_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [11:0]     r_ir;
   logic [15:0]     r_instr_count;
   logic [3:0]      w_op;
   logic [NREG-1:0] w_rx_oh;
   logic [NREG-1:0] w_ry_oh;

   assign w_op    = r_ir[11:8];
   assign w_rx_oh = NREG'(1) << r_ir[6:4];
   assign w_ry_oh = NREG'(1) << r_ir[2:0];

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values of the others; blocking here would create ordering-dependent logic.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ir          <= '0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_T0) r_ir <= din[11:0];
         if (done) r_instr_count <= r_instr_count + 16'd1;
      end
   end

   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE:  w_next_state = run ? S_T0 : S_IDLE;
         S_T0:    w_next_state = S_T1;
         S_T1:    w_next_state = (w_op == OP_ADD || w_op == OP_SUB) ? S_T2 : S_IDLE;
         S_T2:    w_next_state = S_T3;
         S_T3:    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      r_in    = '0;
      r_out   = '0;
      din_out = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      g_out   = 1'b0;
      addsub  = 1'b0;
      pc_incr = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
      case (r_state)
         S_T0: pc_incr = 1'b1;
         S_T1: begin
            case (w_op)
               OP_NOP: done = 1'b1;
               OP_MV: begin
                  r_out = w_ry_oh;
                  r_in  = w_rx_oh;
                  done  = 1'b1;
               end
               OP_MVI: begin
                  din_out = 1'b1;
                  r_in    = w_rx_oh;
                  pc_incr = 1'b1;
                  done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  r_out = w_rx_oh;
                  a_in  = 1'b1;
               end
               default: begin
                  done    = 1'b1;
                  illegal = 1'b1;
               end
            endcase
         end
         S_T2: begin
            r_out  = w_ry_oh;
            g_in   = 1'b1;
            addsub = w_op[2];
         end
         S_T3: begin
            g_out = 1'b1;
            r_in  = w_rx_oh;
            done  = 1'b1;
         end
         default: ;
      endcase
      // Reset masks the decode in the same cycle so a mid-instruction reset never writes.
      if (reset) begin
         r_in    = '0;
         r_out   = '0;
         din_out = 1'b0;
         a_in    = 1'b0;
         g_in    = 1'b0;
         g_out   = 1'b0;
         addsub  = 1'b0;
         pc_incr = 1'b0;
         done    = 1'b0;
         illegal = 1'b0;
      end
   end

   assign ir_out      = r_ir;
   assign instr_count = r_instr_count;

endmodule
